// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-byte holding register with overrun/framing flags.
// Latency: valid rises ~9.5 bit times + 2 cycles after the start edge; no backpressure, a new byte overwrites an unread one.
module uart_rx #(
  parameter int F_CLK = 12000000,
  parameter int BAUD  = 115200,
  parameter int DIV   = F_CLK / BAUD
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       rx,
  input  logic       rd_ack,
  output logic [7:0] data,
  output logic       valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

  generate
    if (DIV < 4) begin : g_div_chk
      $error("uart_rx: DIV must be >= 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic          rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tick;
  logic          load;
  logic          bad_stop;

  assign tick     = (cnt == '0);
  assign load     = (state == STOP) && tick && rx_s;
  assign bad_stop = (state == STOP) && tick && !rx_s;

  // Synchroniser presets to idle-high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (tick) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (tick && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (tick) state_nxt = rx_s ? IDLE : WAIT_HI;
      WAIT_HI: if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    if (state != IDLE) busy = 1'b1;
  end

  // Half-bit preload centres every later sample inside its bit cell.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: if (!rx_s) cnt <= CNT_HALF;
        START: begin
          if (tick) begin
            cnt     <= CNT_FULL;
            bit_idx <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            cnt     <= CNT_FULL;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: if (!tick) cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // A load coinciding with rd_ack wins: the fresh byte stays valid and overrun clears.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      data      <= 8'h00;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (load) begin
        data      <= shift;
        valid     <= 1'b1;
        frame_err <= 1'b0;
        overrun   <= rd_ack ? 1'b0 : (overrun | valid);
      end else if (rd_ack) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
      if (bad_stop) frame_err <= 1'b1;
    end
  end

endmodule
